axil_mem_slave_param: RTL and testbench

- Parametrised AXI4-Lite slave memory model; next generation of the team's fixed 32-bit/128-word slave memory.
- Acts as bench-side memory behind the master DUT.
- Adds generic DATA_W/DEPTH, byte addressing, independent AW/W acceptance in either order, generic per-lane strobe merge, and programmable read latency.
- Out-of-range accesses return DECERR without touching memory.

---
 rtl/axil_mem_pkg.sv | 31 +++
 rtl/axil_mem_strb_merge.sv | 22 ++
 rtl/axil_mem_slave_param.sv | 209 ++++++++++++++++++++
 tb/tb_axil_mem_slave_param.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mem_pkg.sv
// rtl/axil_mem_pkg.sv - shared response codes, FSM state types and address helper for axil_mem_slave_param
//
// Purpose: common definitions imported by the AXI4-Lite memory slave top.
// Contents:
//   RESP_OKAY / RESP_DECERR  - AXI response codes
//   wr_state_t / rd_state_t  - write and read FSM state encodings
//   addr_to_index            - byte address to word index for a 32- or 64-bit bus
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

  // Drops the byte-offset bits inside one data word.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int data_w);
    return (data_w == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage

// File: rtl/axil_mem_strb_merge.sv
// rtl/axil_mem_strb_merge.sv - per-byte-lane merge of write data into an existing memory word
//
// Purpose: combinational strobe merge used on every write commit.
// Ports:
//   old_i    [DATA_W-1:0]    current memory word
//   wdata_i  [DATA_W-1:0]    write data
//   wstrb_i  [DATA_W/8-1:0]  byte lane strobes
//   merged_o [DATA_W-1:0]    old word with strobed lanes replaced
module axil_mem_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic [DATA_W-1:0]   merged_o
);

  for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
    assign merged_o[8*k +: 8] = wstrb_i[k] ? wdata_i[8*k +: 8] : old_i[8*k +: 8];
  end

endmodule

// File: rtl/axil_mem_slave_param.sv
// rtl/axil_mem_slave_param.sv - parametrised AXI4-Lite slave memory with strobe merge and programmable read latency
//
// Purpose: bench-side memory behind an AXI4-Lite master. Words beyond DEPTH
// answer DECERR and are never written; reads of them return zero.
// Ports:
//   mem_axi_aclk / mem_axi_areset            clock, synchronous active-high reset
//   AW: awvalid, awready, awaddr             write address channel (byte address)
//   W : wvalid, wready, wdata, wstrb         write data channel
//   B : bvalid, bready, bresp                write response channel
//   AR: arvalid, arready, araddr             read address channel (byte address)
//   R : rvalid, rready, rdata, rresp         read data channel
module axil_mem_slave_param
  import axil_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 128,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                mem_axi_aclk,
  input  logic                mem_axi_areset,
  input  logic                mem_axi_awvalid,
  output logic                mem_axi_awready,
  input  logic [ADDR_W-1:0]   mem_axi_awaddr,
  input  logic                mem_axi_wvalid,
  output logic                mem_axi_wready,
  input  logic [DATA_W-1:0]   mem_axi_wdata,
  input  logic [DATA_W/8-1:0] mem_axi_wstrb,
  output logic                mem_axi_bvalid,
  input  logic                mem_axi_bready,
  output logic [1:0]          mem_axi_bresp,
  input  logic                mem_axi_arvalid,
  output logic                mem_axi_arready,
  input  logic [ADDR_W-1:0]   mem_axi_araddr,
  output logic                mem_axi_rvalid,
  input  logic                mem_axi_rready,
  output logic [DATA_W-1:0]   mem_axi_rdata,
  output logic [1:0]          mem_axi_rresp
);

  localparam int         STRB_W  = DATA_W / 8;
  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] RD_LOAD = 3'(RD_LAT - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------- write path ----------------
  wr_state_t         wr_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs, w_hs, have_aw, have_w, wr_commit, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, wr_old, wr_merged;
  logic [STRB_W-1:0] wr_strb;
  logic [63:0]       wr_idx;

  assign aw_hs   = mem_axi_awvalid & awready_q;
  assign w_hs    = mem_axi_wvalid & wready_q;
  // A channel counts as present if it is held or handshaking right now, so the
  // commit fires in the cycle the second half arrives.
  assign have_aw   = aw_hs | (wr_state_q == W_HAVE_AW);
  assign have_w    = w_hs | (wr_state_q == W_HAVE_W);
  assign wr_commit = have_aw & have_w;

  assign wr_addr = (wr_state_q == W_HAVE_AW) ? awaddr_q : mem_axi_awaddr;
  assign wr_data = (wr_state_q == W_HAVE_W) ? wdata_q : mem_axi_wdata;
  assign wr_strb = (wr_state_q == W_HAVE_W) ? wstrb_q : mem_axi_wstrb;

  assign wr_idx      = addr_to_index(64'(wr_addr), DATA_W);
  assign wr_in_range = wr_idx < 64'(DEPTH);
  assign wr_old      = mem_q[wr_idx[IDX_W-1:0]];

  axil_mem_strb_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i    (wr_old),
    .wdata_i  (wr_data),
    .wstrb_i  (wr_strb),
    .merged_o (wr_merged)
  );

  always_ff @(posedge mem_axi_aclk) begin
    if (mem_axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (INIT_MODE == 1) ? DATA_W'(2 * i) : '0;
      end
    end else if (wr_commit) begin
      if (wr_in_range) begin
        mem_q[wr_idx[IDX_W-1:0]] <= wr_merged;
      end
      bresp_q    <= wr_in_range ? RESP_OKAY : RESP_DECERR;
      bvalid_q   <= 1'b1;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      wr_state_q <= W_RESP;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          if (aw_hs) begin
            awaddr_q   <= mem_axi_awaddr;
            awready_q  <= 1'b0;
            wr_state_q <= W_HAVE_AW;
          end else if (w_hs) begin
            wdata_q    <= mem_axi_wdata;
            wstrb_q    <= mem_axi_wstrb;
            wready_q   <= 1'b0;
            wr_state_q <= W_HAVE_W;
          end
        end
        W_RESP: begin
          if (mem_axi_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: ;  // holding one channel; the commit branch handles the other
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t         rd_state_q;
  logic              arready_q, rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        rd_cnt_q, rd_cnt_d;

  logic              ar_hs, rd_sample, rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign ar_hs    = mem_axi_arvalid & arready_q;
  assign rd_cnt_d = (rd_state_q == R_IDLE) ? RD_LOAD : rd_cnt_q - 3'd1;
  // The sample happens in the cycle the counter's next value is zero; with
  // RD_LAT = 1 that is the AR handshake cycle itself.
  assign rd_sample = (ar_hs | (rd_state_q == R_WAIT)) & (rd_cnt_d == 3'd0);
  assign rd_addr   = (rd_state_q == R_IDLE) ? mem_axi_araddr : araddr_q;

  assign rd_idx      = addr_to_index(64'(rd_addr), DATA_W);
  assign rd_in_range = rd_idx < 64'(DEPTH);
  assign rd_word     = mem_q[rd_idx[IDX_W-1:0]];

  always_ff @(posedge mem_axi_aclk) begin
    if (mem_axi_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      araddr_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            araddr_q   <= mem_axi_araddr;
            rd_cnt_q   <= rd_cnt_d;
            arready_q  <= 1'b0;
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT: rd_cnt_q <= rd_cnt_d;
        R_DATA: begin
          if (mem_axi_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
      // mem_q is read before any same-edge commit lands, so a colliding read sees old data.
      if (rd_sample) begin
        rvalid_q   <= 1'b1;
        rdata_q    <= rd_in_range ? rd_word : '0;
        rresp_q    <= rd_in_range ? RESP_OKAY : RESP_DECERR;
        rd_state_q <= R_DATA;
      end
    end
  end

  assign mem_axi_awready = awready_q;
  assign mem_axi_wready  = wready_q;
  assign mem_axi_bvalid  = bvalid_q;
  assign mem_axi_bresp   = bresp_q;
  assign mem_axi_arready = arready_q;
  assign mem_axi_rvalid  = rvalid_q;
  assign mem_axi_rdata   = rdata_q;
  assign mem_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_mem_slave_param.sv
// tb/tb_axil_mem_slave_param.sv - randomized self-checking bench for axil_mem_slave_param against an array model
module tb_axil_mem_slave_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance: 32-bit, RD_LAT 1, INIT_MODE 1
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [31:0] a_awaddr, a_araddr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_bresp, a_rresp;

  // second instance: 64-bit, RD_LAT 4, INIT_MODE 0
  logic        x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
  logic        x_arvalid, x_arready, x_rvalid, x_rready;
  logic [31:0] x_awaddr, x_araddr;
  logic [63:0] x_wdata, x_rdata;
  logic [7:0]  x_wstrb;
  logic [1:0]  x_bresp, x_rresp;

  axil_mem_slave_param dut_a (
    .mem_axi_aclk(clk), .mem_axi_areset(rst),
    .mem_axi_awvalid(a_awvalid), .mem_axi_awready(a_awready), .mem_axi_awaddr(a_awaddr),
    .mem_axi_wvalid(a_wvalid), .mem_axi_wready(a_wready), .mem_axi_wdata(a_wdata), .mem_axi_wstrb(a_wstrb),
    .mem_axi_bvalid(a_bvalid), .mem_axi_bready(a_bready), .mem_axi_bresp(a_bresp),
    .mem_axi_arvalid(a_arvalid), .mem_axi_arready(a_arready), .mem_axi_araddr(a_araddr),
    .mem_axi_rvalid(a_rvalid), .mem_axi_rready(a_rready), .mem_axi_rdata(a_rdata), .mem_axi_rresp(a_rresp)
  );

  axil_mem_slave_param #(.DATA_W(64), .RD_LAT(4), .INIT_MODE(0)) dut_x (
    .mem_axi_aclk(clk), .mem_axi_areset(rst),
    .mem_axi_awvalid(x_awvalid), .mem_axi_awready(x_awready), .mem_axi_awaddr(x_awaddr),
    .mem_axi_wvalid(x_wvalid), .mem_axi_wready(x_wready), .mem_axi_wdata(x_wdata), .mem_axi_wstrb(x_wstrb),
    .mem_axi_bvalid(x_bvalid), .mem_axi_bready(x_bready), .mem_axi_bresp(x_bresp),
    .mem_axi_arvalid(x_arvalid), .mem_axi_arready(x_arready), .mem_axi_araddr(x_araddr),
    .mem_axi_rvalid(x_rvalid), .mem_axi_rready(x_rready), .mem_axi_rdata(x_rdata), .mem_axi_rresp(x_rresp)
  );

  int          errs;
  int          checks;
  logic [31:0] model_a [128];
  logic [63:0] model_x [128];
  logic [31:0] rd_d, addr;
  logic [1:0]  rd_r;
  logic [63:0] xdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lead > 0: AW offered lead cycles before W; lead < 0: W first.
  task automatic wr32(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb,
                      input int lead, input int bwait);
    int          aw_at, w_at, cyc;
    bit          aw_done, w_done, aw_hs, w_hs;
    logic [31:0] idx;
    logic [1:0]  exp_resp;
    aw_at = (lead < 0) ? -lead : 0;
    w_at  = (lead > 0) ? lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      a_awvalid = !aw_done && (cyc >= aw_at);
      a_awaddr  = adr;
      a_wvalid  = !w_done && (cyc >= w_at);
      a_wdata   = data;
      a_wstrb   = strb;
      aw_hs = a_awvalid && a_awready;
      w_hs  = a_wvalid && a_wready;
      tick();
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    a_awvalid = 1'b0;
    a_wvalid  = 1'b0;
    check_eq("wr_handshake", 64'(aw_done && w_done), 64'd1);
    idx = adr >> 2;
    exp_resp = (idx < 128) ? 2'b00 : 2'b11;
    if (idx < 128) model_a[idx[6:0]] = 32'(merge(64'(model_a[idx[6:0]]), 64'(data), 8'(strb)));
    check_eq("bvalid_rise", 64'(a_bvalid), 64'd1);
    for (int i = 0; i < bwait; i++) begin
      check_eq("bresp_hold", 64'(a_bresp), 64'(exp_resp));
      check_eq("awready_in_resp", 64'(a_awready), 64'd0);
      check_eq("wready_in_resp", 64'(a_wready), 64'd0);
      tick();
      check_eq("bvalid_hold", 64'(a_bvalid), 64'd1);
    end
    check_eq("bresp", 64'(a_bresp), 64'(exp_resp));
    a_bready = 1'b1;
    tick();
    a_bready = 1'b0;
    check_eq("bvalid_drop", 64'(a_bvalid), 64'd0);
    check_eq("awready_after_b", 64'(a_awready), 64'd1);
    check_eq("wready_after_b", 64'(a_wready), 64'd1);
  endtask

  task automatic rd32(input logic [31:0] adr, input int rwait, output logic [31:0] d, output logic [1:0] r);
    int          n;
    bit          hs;
    logic [31:0] idx, exp_d;
    logic [1:0]  exp_r;
    a_arvalid = 1'b1;
    a_araddr  = adr;
    hs = 0; n = 0;
    while (!hs && n < 40) begin
      hs = a_arready;
      tick();
      n++;
    end
    a_arvalid = 1'b0;
    check_eq("ar_handshake", 64'(hs), 64'd1);
    n = 1;
    while (!a_rvalid && n < 20) begin
      tick();
      n++;
    end
    check_eq("rd_latency", 64'(n), 64'd1);
    idx   = adr >> 2;
    exp_d = (idx < 128) ? model_a[idx[6:0]] : 32'd0;
    exp_r = (idx < 128) ? 2'b00 : 2'b11;
    for (int i = 0; i < rwait; i++) begin
      tick();
      check_eq("rvalid_hold", 64'(a_rvalid), 64'd1);
    end
    check_eq("rdata", 64'(a_rdata), 64'(exp_d));
    check_eq("rresp", 64'(a_rresp), 64'(exp_r));
    d = a_rdata;
    r = a_rresp;
    a_rready = 1'b1;
    tick();
    a_rready = 1'b0;
    check_eq("rvalid_drop", 64'(a_rvalid), 64'd0);
  endtask

  task automatic wr64(input logic [31:0] adr, input logic [63:0] data, input logic [7:0] strb);
    int          cyc;
    bit          hs;
    logic [31:0] idx;
    x_awvalid = 1'b1; x_wvalid = 1'b1;
    x_awaddr = adr; x_wdata = data; x_wstrb = strb;
    x_bready = 1'b1;  // bready high before bvalid
    hs = 0; cyc = 0;
    while (!hs && cyc < 20) begin
      hs = x_awready && x_wready;
      tick();
      cyc++;
    end
    x_awvalid = 1'b0; x_wvalid = 1'b0;
    check_eq("x_wr_handshake", 64'(hs), 64'd1);
    idx = adr >> 3;
    check_eq("x_bvalid", 64'(x_bvalid), 64'd1);
    check_eq("x_bresp", 64'(x_bresp), (idx < 128) ? 64'd0 : 64'd3);
    if (idx < 128) model_x[idx[6:0]] = merge(model_x[idx[6:0]], data, strb);
    tick();
    x_bready = 1'b0;
    check_eq("x_bvalid_drop", 64'(x_bvalid), 64'd0);
  endtask

  task automatic rd64(input logic [31:0] adr);
    int          n;
    bit          hs;
    logic [31:0] idx;
    x_arvalid = 1'b1;
    x_araddr  = adr;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      hs = x_arready;
      tick();
      n++;
    end
    x_arvalid = 1'b0;
    check_eq("x_ar_handshake", 64'(hs), 64'd1);
    n = 1;
    while (!x_rvalid && n < 20) begin
      tick();
      n++;
    end
    check_eq("x_rd_latency", 64'(n), 64'd4);
    idx = adr >> 3;
    check_eq("x_rdata", x_rdata, (idx < 128) ? model_x[idx[6:0]] : 64'd0);
    check_eq("x_rresp", 64'(x_rresp), (idx < 128) ? 64'd0 : 64'd3);
    x_rready = 1'b1;
    tick();
    x_rready = 1'b0;
    check_eq("x_rvalid_drop", 64'(x_rvalid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errs = 0; checks = 0;
    rst = 1'b1;
    a_awvalid = 0; a_wvalid = 0; a_bready = 0; a_arvalid = 0; a_rready = 0;
    a_awaddr = 0; a_araddr = 0; a_wdata = 0; a_wstrb = 0;
    x_awvalid = 0; x_wvalid = 0; x_bready = 0; x_arvalid = 0; x_rready = 0;
    x_awaddr = 0; x_araddr = 0; x_wdata = 0; x_wstrb = 0;
    for (int i = 0; i < 128; i++) begin
      model_a[i] = 32'(2 * i);
      model_x[i] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", 64'(a_awready), 64'd0);
    check_eq("rst_wready", 64'(a_wready), 64'd0);
    check_eq("rst_arready", 64'(a_arready), 64'd0);
    check_eq("rst_bvalid", 64'(a_bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(a_rvalid), 64'd0);
    check_eq("rst_rdata", 64'(a_rdata), 64'd0);
    check_eq("rst_x_rdata", x_rdata, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_awready", 64'(a_awready), 64'd1);
    check_eq("post_rst_wready", 64'(a_wready), 64'd1);
    check_eq("post_rst_arready", 64'(a_arready), 64'd1);
    check_eq("post_rst_x_arready", 64'(x_arready), 64'd1);

    // defaults: word 3 reads 2*3
    rd32(32'h0C, 0, rd_d, rd_r);
    check_eq("t1_word3", 64'(rd_d), 64'h6);
    // AW three cycles ahead of W, strobes on lanes 0 and 2
    wr32(32'h10, 32'hAABB_CCDD, 4'b0101, 3, 0);
    rd32(32'h10, 1, rd_d, rd_r);
    check_eq("t2_word4", 64'(rd_d), 64'h00BB_00DD);
    // W ahead of AW, bready held low for four cycles
    wr32(32'h20, 32'h1234_5678, 4'b1111, -2, 4);
    // zero strobe is an OKAY no-op
    wr32(32'h24, 32'hFFFF_FFFF, 4'b0000, 0, 1);
    // word 128 is out of range
    wr32(32'h200, 32'hCAFE_F00D, 4'b1111, 0, 0);
    rd32(32'h200, 0, rd_d, rd_r);
    check_eq("t4_oor_rresp", 64'(rd_r), 64'd3);
    check_eq("t4_oor_rdata", 64'(rd_d), 64'd0);

    for (int it = 0; it < 60; it++) begin
      addr = $urandom_range(32'h23F, 0);
      if ($urandom_range(9, 0) == 0) addr = $urandom();
      if ($urandom_range(1, 0) == 1)
        wr32(addr, $urandom(), 4'($urandom()), int'($urandom_range(6, 0)) - 3, int'($urandom_range(3, 0)));
      else
        rd32(addr, int'($urandom_range(2, 0)), rd_d, rd_r);
    end
    for (int i = 0; i < 128; i++) rd32(32'(4 * i) + 32'($urandom_range(3, 0)), 0, rd_d, rd_r);

    // 64-bit, RD_LAT 4: commit to word 2 lands in the read's sample cycle
    check_eq("t5_arready", 64'(x_arready), 64'd1);
    x_arvalid = 1'b1;
    x_araddr  = 32'h10;
    tick();
    x_arvalid = 1'b0;
    check_eq("t5_rvalid_n1", 64'(x_rvalid), 64'd0);
    tick();
    check_eq("t5_rvalid_n2", 64'(x_rvalid), 64'd0);
    tick();
    check_eq("t5_rvalid_n3", 64'(x_rvalid), 64'd0);
    check_eq("t5_awready", 64'(x_awready), 64'd1);
    xdata = {$urandom(), $urandom()} | 64'h1;
    x_awvalid = 1'b1; x_wvalid = 1'b1;
    x_awaddr = 32'h10; x_wdata = xdata; x_wstrb = 8'hFF;
    tick();
    x_awvalid = 1'b0; x_wvalid = 1'b0;
    check_eq("t5_rvalid_n4", 64'(x_rvalid), 64'd1);
    check_eq("t5_old_data", x_rdata, 64'd0);
    check_eq("t5_rresp", 64'(x_rresp), 64'd0);
    check_eq("t5_bvalid", 64'(x_bvalid), 64'd1);
    model_x[2] = xdata;
    x_rready = 1'b1; x_bready = 1'b1;
    tick();
    x_rready = 1'b0; x_bready = 1'b0;
    check_eq("t5_rvalid_drop", 64'(x_rvalid), 64'd0);
    check_eq("t5_bvalid_drop", 64'(x_bvalid), 64'd0);
    rd64(32'h10);
    for (int it = 0; it < 12; it++) begin
      addr = 32'($urandom_range(131, 0)) << 3;
      wr64(addr, {$urandom(), $urandom()}, 8'($urandom()));
      rd64(addr | 32'($urandom_range(7, 0)));
    end

    // reset with both B and R beats pending
    a_awvalid = 1'b1; a_wvalid = 1'b1;
    a_awaddr = 32'h14; a_wdata = 32'hDEAD_BEEF; a_wstrb = 4'hF;
    tick();
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    check_eq("t6_bvalid", 64'(a_bvalid), 64'd1);
    a_arvalid = 1'b1;
    a_araddr  = 32'h14;
    tick();
    a_arvalid = 1'b0;
    check_eq("t6_rvalid", 64'(a_rvalid), 64'd1);
    check_eq("t6_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    check_eq("t6_bvalid_rst", 64'(a_bvalid), 64'd0);
    check_eq("t6_rvalid_rst", 64'(a_rvalid), 64'd0);
    check_eq("t6_awready_rst", 64'(a_awready), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("t6_awready", 64'(a_awready), 64'd1);
    check_eq("t6_wready", 64'(a_wready), 64'd1);
    check_eq("t6_arready", 64'(a_arready), 64'd1);
    check_eq("t6_x_awready", 64'(x_awready), 64'd1);
    for (int i = 0; i < 128; i++) begin
      model_a[i] = 32'(2 * i);
      model_x[i] = 64'd0;
    end
    rd32(32'h14, 0, rd_d, rd_r);
    check_eq("t6_word5_reinit", 64'(rd_d), 64'd10);
    rd64(32'h10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
